// File: rtl/clcd_pkg.sv
// Shared definitions for the character-LCD write arbiter: FSM state encoding,
// the power-on init command bytes and the slow clear/home opcodes.
package clcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT_HI = 3'd0,
    ST_INIT_LO = 3'd1,
    ST_IDLE    = 3'd2,
    ST_WR_HI   = 3'd3,
    ST_WR_LO   = 3'd4
  } state_t;

  localparam int         INIT_COUNT    = 4;
  localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0F;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;

  // Init command issued at position idx of the power-on sequence.
  function automatic logic [7:0] initCmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Clear and home are the two commands the LCD takes much longer to execute.
  function automatic logic needsExtra(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/clcd_strobe_timer.sv
// Phase timer for the LCD enable strobe: one shared counter, restarted on
// every phase change, flagging the end of the high, low and extended-low
// phases. The counter saturates instead of wrapping.
module clcd_strobe_timer #(
  parameter int E_HIGH    = 20000,
  parameter int E_LOW     = 20000,
  parameter int CLR_EXTRA = 80000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic restart_i,
  input  logic hold_i,
  output logic hiDone_o,
  output logic loDone_o,
  output logic clrDone_o
);

  localparam int LO_TOTAL = E_LOW + CLR_EXTRA;
  localparam int CNT_MAX  = (E_HIGH > LO_TOTAL) ? E_HIGH : LO_TOTAL;
  localparam int CW       = $clog2(CNT_MAX + 1);

  logic [CW-1:0] cnt_q;

  // Count cycles within the current phase; hold freezes it, restart reloads 0.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
    end else if (!hold_i && (cnt_q != CW'(CNT_MAX))) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign hiDone_o  = !hold_i && (cnt_q == CW'(E_HIGH - 1));
  assign loDone_o  = !hold_i && (cnt_q == CW'(E_LOW - 1));
  assign clrDone_o = !hold_i && (cnt_q == CW'(LO_TOTAL - 1));

endmodule

// File: rtl/clcd_arbiter.sv
// Two-requester round-robin arbiter driving a character LCD bus. After reset
// it runs the power-on init sequence, then grants one pending byte at a time
// and strobes it onto the LCD with LCD_E.
module clcd_arbiter
  import clcd_pkg::*;
#(
  parameter int E_HIGH    = 20000,
  parameter int E_LOW     = 20000,
  parameter int CLR_EXTRA = 80000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       RS0,
  input  logic       RS1,
  input  logic [7:0] DIN0,
  input  logic [7:0] DIN1,
  output logic       ACK0,
  output logic       ACK1,
  output logic [7:0] DATA,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       INIT_DONE,
  output logic       BUSY
);

  state_t     state_q;
  logic [1:0] initIdx_q;
  logic [7:0] data_q;
  logic       rs_q;
  logic       lcdE_q;
  logic       initDone_q;
  logic       lastGnt_q;

  logic hiDone;
  logic loDone;
  logic clrDone;
  logic phaseEnd;
  logic grant0;
  logic grant1;
  logic grantAny;
  logic extraLow;
  logic timerHold;

  // The cycle straight out of reset has LCD_E low; the timer waits for the
  // strobe to rise so the first init byte still gets a full high phase.
  assign timerHold = (state_q == ST_INIT_HI) && !lcdE_q;
  assign grantAny  = grant0 || grant1;

  clcd_strobe_timer #(
    .E_HIGH   (E_HIGH),
    .E_LOW    (E_LOW),
    .CLR_EXTRA(CLR_EXTRA)
  ) u_timer (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .restart_i(phaseEnd || grantAny),
    .hold_i   (timerHold),
    .hiDone_o (hiDone),
    .loDone_o (loDone),
    .clrDone_o(clrDone)
  );

  // Decode the same-cycle grant and the end of the current strobe phase.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    phaseEnd = 1'b0;
    extraLow = needsExtra(rs_q, data_q);
    if ((state_q == ST_IDLE) && initDone_q) begin
      grant0 = REQ0 && (!REQ1 || lastGnt_q);
      grant1 = REQ1 && (!REQ0 || !lastGnt_q);
    end
    case (state_q)
      ST_INIT_HI, ST_WR_HI: phaseEnd = hiDone;
      ST_INIT_LO, ST_WR_LO: phaseEnd = extraLow ? clrDone : loDone;
      default:              phaseEnd = 1'b0;
    endcase
  end

  // Main FSM: init sequence, idle arbitration and the write strobe phases.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_INIT_HI;
      initIdx_q  <= 2'd0;
      data_q     <= CMD_FUNC_SET;
      rs_q       <= 1'b0;
      lcdE_q     <= 1'b0;
      initDone_q <= 1'b0;
      lastGnt_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT_HI: begin
          if (phaseEnd) begin
            state_q <= ST_INIT_LO;
            lcdE_q  <= 1'b0;
          end else begin
            lcdE_q  <= 1'b1;
          end
        end
        ST_INIT_LO: begin
          if (phaseEnd) begin
            if (initIdx_q == 2'(INIT_COUNT - 1)) begin
              state_q    <= ST_IDLE;
              initDone_q <= 1'b1;
            end else begin
              initIdx_q <= initIdx_q + 2'd1;
              data_q    <= initCmd(initIdx_q + 2'd1);
              state_q   <= ST_INIT_HI;
              lcdE_q    <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (grantAny) begin
            state_q   <= ST_WR_HI;
            lcdE_q    <= 1'b1;
            data_q    <= grant1 ? DIN1 : DIN0;
            rs_q      <= grant1 ? RS1 : RS0;
            lastGnt_q <= grant1;
          end
        end
        ST_WR_HI: begin
          if (phaseEnd) begin
            state_q <= ST_WR_LO;
            lcdE_q  <= 1'b0;
          end
        end
        ST_WR_LO: begin
          if (phaseEnd) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_INIT_HI;
          lcdE_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ACK0      = grant0;
  assign ACK1      = grant1;
  assign DATA      = data_q;
  assign LCD_RS    = rs_q;
  assign LCD_E     = lcdE_q;
  assign INIT_DONE = initDone_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clcd_arbiter.sv
// Scoreboard bench for clcd_arbiter with short strobe timings. Stimulus pushes
// the expected strobes and acknowledges; two monitors pop and compare them as
// the DUT produces LCD_E pulses and ACK pulses.
module tb_clcd_arbiter;

  localparam int EH = 4;
  localparam int EL = 4;
  localparam int CX = 8;

  logic       CLK    = 1'b0;
  logic       RESETN = 1'b1;
  logic       REQ0   = 1'b0;
  logic       REQ1   = 1'b0;
  logic       RS0    = 1'b0;
  logic       RS1    = 1'b0;
  logic [7:0] DIN0   = 8'h00;
  logic [7:0] DIN1   = 8'h00;
  logic       ACK0;
  logic       ACK1;
  logic [7:0] DATA;
  logic       LCD_E;
  logic       LCD_RS;
  logic       INIT_DONE;
  logic       BUSY;

  clcd_arbiter #(
    .E_HIGH   (EH),
    .E_LOW    (EL),
    .CLR_EXTRA(CX)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .REQ0     (REQ0),
    .REQ1     (REQ1),
    .RS0      (RS0),
    .RS1      (RS1),
    .DIN0     (DIN0),
    .DIN1     (DIN1),
    .ACK0     (ACK0),
    .ACK1     (ACK1),
    .DATA     (DATA),
    .LCD_E    (LCD_E),
    .LCD_RS   (LCD_RS),
    .INIT_DONE(INIT_DONE),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         hi;
    int         lo;
    logic       done;
  } strobe_t;

  typedef struct {
    int id;
    int gap;
  } ack_t;

  strobe_t expStrobe[$];
  ack_t    expAck[$];
  int      checks = 0;
  int      passes = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, actual, actual, expected, expected, $time);
  endtask

  task automatic pushStrobe(input logic [7:0] d, input logic rs, input int lo, input logic done);
    strobe_t s;
    s.data = d; s.rs = rs; s.hi = EH; s.lo = lo; s.done = done;
    expStrobe.push_back(s);
  endtask

  task automatic pushAck(input int id, input int gap);
    ack_t a;
    a.id = id; a.gap = gap;
    expAck.push_back(a);
  endtask

  task automatic pushInit();
    pushStrobe(8'h38, 1'b0, EL, 1'b0);
    pushStrobe(8'h0F, 1'b0, EL, 1'b0);
    pushStrobe(8'h06, 1'b0, EL, 1'b0);
    pushStrobe(8'h01, 1'b0, EL + CX, 1'b1);
  endtask

  task automatic applyStimulus(input logic r0, input logic s0, input logic [7:0] d0,
                               input logic r1, input logic s1, input logic [7:0] d1);
    @(posedge CLK);
    #1;
    REQ0 = r0; RS0 = s0; DIN0 = d0;
    REQ1 = r1; RS1 = s1; DIN1 = d1;
  endtask

  task automatic waitAck(input int id);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      if ((id == 0 && ACK0) || (id == 1 && ACK1)) seen = 1'b1;
    end
    if (!seen) checkOutput("ackTimeout", 0, 1);
  endtask

  task automatic waitIdle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      if (!BUSY) seen = 1'b1;
    end
    if (!seen) checkOutput("idleTimeout", 0, 1);
  endtask

  task automatic checkResetValues();
    checkOutput("rstData", int'(DATA), 8'h38);
    checkOutput("rstLcdE", int'(LCD_E), 0);
    checkOutput("rstLcdRs", int'(LCD_RS), 0);
    checkOutput("rstInitDone", int'(INIT_DONE), 0);
    checkOutput("rstBusy", int'(BUSY), 1);
    checkOutput("rstAck0", int'(ACK0), 0);
    checkOutput("rstAck1", int'(ACK1), 0);
  endtask

  // Strobe monitor: measures each LCD_E pulse and the low time that follows it.
  int         inHi = 0;
  int         inLo = 0;
  int         hiLen = 0;
  int         loLen = 0;
  logic [7:0] capData = 8'h00;
  logic       capRs = 1'b0;
  strobe_t    es;

  always @(negedge CLK) begin
    if (!RESETN) begin
      inHi = 0;
      inLo = 0;
    end else begin
      if (inLo != 0) begin
        if (LCD_E || !BUSY) begin
          inLo = 0;
          if (expStrobe.size() == 0) begin
            checkOutput("unexpectedStrobe", int'(capData), -1);
          end else begin
            es = expStrobe.pop_front();
            checkOutput("strobeData", int'(capData), int'(es.data));
            checkOutput("strobeRs", int'(capRs), int'(es.rs));
            checkOutput("strobeHigh", hiLen, es.hi);
            checkOutput("strobeLow", loLen, es.lo);
            checkOutput("strobeInitDone", int'(INIT_DONE), int'(es.done));
          end
        end else begin
          loLen++;
        end
      end
      if (LCD_E) begin
        if (inHi == 0) begin
          inHi    = 1;
          hiLen   = 0;
          capData = DATA;
          capRs   = LCD_RS;
        end
        hiLen++;
      end else if (inHi != 0) begin
        inHi  = 0;
        inLo  = 1;
        loLen = 1;
      end
    end
  end

  // Ack monitor: checks who was acknowledged and the spacing between grants.
  int   gap = 0;
  logic prevDone = 1'b0;
  int   ackId;
  ack_t ea;

  always @(negedge CLK) begin
    if (!RESETN) begin
      gap      = 0;
      prevDone = 1'b0;
    end else begin
      if (INIT_DONE && !prevDone) gap = 0;
      else gap++;
      prevDone = INIT_DONE;
      if (ACK0 || ACK1) begin
        ackId = (ACK0 && ACK1) ? 2 : (ACK1 ? 1 : 0);
        if (expAck.size() == 0) begin
          checkOutput("unexpectedAck", ackId, -1);
        end else begin
          ea = expAck.pop_front();
          checkOutput("ackId", ackId, ea.id);
          checkOutput("ackInitDone", int'(INIT_DONE), 1);
          if (ea.gap >= 0) checkOutput("ackGap", gap, ea.gap);
        end
        gap = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 RESETN = 1'b0;
    #2;
    $display("[TB] reset values");
    checkResetValues();

    // Init sequence with REQ0 raised part-way through: first IDLE cycle grants it.
    pushInit();
    pushAck(0, 0);
    pushStrobe(8'h41, 1'b1, EL, 1'b1);
    repeat (3) @(posedge CLK);
    #1 RESETN = 1'b1;
    repeat (5) @(posedge CLK);
    applyStimulus(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    waitAck(0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    waitIdle();

    // Clear command from requester 1 stretches the low phase.
    $display("[TB] clear command on requester 1");
    pushAck(1, -1);
    pushStrobe(8'h01, 1'b0, EL + CX, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01);
    waitAck(1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    waitIdle();

    // Both requesters held: round-robin, back-to-back spacing EH+EL+1.
    $display("[TB] round robin");
    pushAck(0, -1);
    pushAck(1, EH + EL + 1);
    pushAck(0, EH + EL + 1);
    pushAck(1, EH + EL + 1);
    pushStrobe(8'h55, 1'b1, EL, 1'b1);
    pushStrobe(8'hAA, 1'b1, EL, 1'b1);
    pushStrobe(8'h55, 1'b1, EL, 1'b1);
    pushStrobe(8'hAA, 1'b1, EL, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'hAA);
    waitAck(0);
    waitAck(1);
    waitAck(0);
    waitAck(1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    waitIdle();

    // Reset in the middle of a write strobe: the write is abandoned.
    $display("[TB] reset during write");
    pushAck(0, -1);
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
    waitAck(0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge CLK);
    #1 RESETN = 1'b0;
    #1;
    checkResetValues();

    // Tie held through reset and init: requester 0 wins, home command stretches low.
    pushInit();
    pushAck(0, 0);
    pushAck(1, EH + EL + CX + 1);
    pushStrobe(8'h02, 1'b0, EL + CX, 1'b1);
    pushStrobe(8'h33, 1'b1, EL, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 8'h33);
    repeat (2) @(posedge CLK);
    #1 RESETN = 1'b1;
    waitAck(0);
    waitAck(1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    waitIdle();
    repeat (5) @(posedge CLK);

    checkOutput("pendingStrobes", expStrobe.size(), 0);
    checkOutput("pendingAcks", expAck.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
